// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes,
// multi-cycle ALU occupancy and a saturating stall counter.
module pipeline_hazard_ctrl #(
  parameter int          REG_W  = 5,
  parameter int          MC_LAT = 4,
  parameter logic [3:0]  MC_OP0 = 4'b1010,
  parameter logic [3:0]  MC_OP1 = 4'b1011
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs1_id,
  input  logic [REG_W-1:0] rs2_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic [REG_W-1:0] rd_ex,
  input  logic             memread_ex,
  input  logic [3:0]       ALUOp_ex,
  input  logic             branch_taken_ex,
  output logic             stall_if,
  output logic             stall_id,
  output logic             clrHDU,
  output logic             clrBU,
  output logic             alu_busy,
  output logic             mc_start,
  output logic             mc_done,
  output logic [15:0]      stall_cnt
);

  typedef enum logic {
    RUN,
    MC_BUSY
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MC_LAT - 2);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        lu_haz;
  logic        is_mc;
  logic        hold;

  assign lu_haz = memread_ex && (rd_ex != '0) &&
                  ((use_rs1_id && (rs1_id == rd_ex)) ||
                   (use_rs2_id && (rs2_id == rd_ex)));

  assign is_mc = (ALUOp_ex == MC_OP0) || (ALUOp_ex == MC_OP1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold     = 1'b0;
    clrBU    = 1'b0;
    alu_busy = 1'b0;
    mc_start = 1'b0;
    mc_done  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (branch_taken_ex) begin
          clrBU = 1'b1;
        end else if (is_mc) begin
          hold     = 1'b1;
          mc_start = 1'b1;
          cnt_d    = CNT_INIT;
          state_d  = MC_BUSY;
        end else if (lu_haz) begin
          hold = 1'b1;
        end
      end
      MC_BUSY: begin
        hold     = 1'b1;
        alu_busy = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mc_done = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    // Reset masks every output, so an aborted op never reports done
    if (!rst_n) begin
      hold     = 1'b0;
      clrBU    = 1'b0;
      alu_busy = 1'b0;
      mc_start = 1'b0;
      mc_done  = 1'b0;
      state_d  = RUN;
      cnt_d    = '0;
    end
  end

  assign stall_if = hold;
  assign stall_id = hold;
  assign clrHDU   = hold;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hold && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = rst_n ? stall_cnt_q : 16'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MC_LAT=4.
// Outputs are checked at the falling edge; inputs change just after rising.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic       use_rs1_id, use_rs2_id, memread_ex, branch_taken_ex;
  logic [3:0] ALUOp_ex;
  logic       stall_if, stall_id, clrHDU, clrBU;
  logic       alu_busy, mc_start, mc_done;
  logic [15:0] stall_cnt;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_W (5),
    .MC_LAT(4),
    .MC_OP0(4'b1010),
    .MC_OP1(4'b1011)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs1_id         (rs1_id),
    .rs2_id         (rs2_id),
    .use_rs1_id     (use_rs1_id),
    .use_rs2_id     (use_rs2_id),
    .rd_ex          (rd_ex),
    .memread_ex     (memread_ex),
    .ALUOp_ex       (ALUOp_ex),
    .branch_taken_ex(branch_taken_ex),
    .stall_if       (stall_if),
    .stall_id       (stall_id),
    .clrHDU         (clrHDU),
    .clrBU          (clrBU),
    .alu_busy       (alu_busy),
    .mc_start       (mc_start),
    .mc_done        (mc_done),
    .stall_cnt      (stall_cnt)
  );

  // {stall_if, stall_id, clrHDU, clrBU, alu_busy, mc_start, mc_done}
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] LU   = 7'b1110000;
  localparam logic [6:0] BR   = 7'b0001000;
  localparam logic [6:0] MCS  = 7'b1110010;
  localparam logic [6:0] BUSY = 7'b1110100;
  localparam logic [6:0] DONE = 7'b1110101;

  task automatic check(input string tag, input logic [6:0] exp_ctl,
                       input logic [15:0] exp_sc);
    logic [6:0] ctl;
    @(negedge clk);
    ctl = {stall_if, stall_id, clrHDU, clrBU, alu_busy, mc_start, mc_done};
    ncmp++;
    assert (ctl === exp_ctl) else begin
      nerr++;
      $error("FAIL %s ctl observed=%b expected=%b", tag, ctl, exp_ctl);
    end
    ncmp++;
    assert (stall_cnt === exp_sc) else begin
      nerr++;
      $error("FAIL %s stall_cnt observed=%0h expected=%0h", tag, stall_cnt, exp_sc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0;
    use_rs1_id = 1'b0; use_rs2_id = 1'b0;
    memread_ex = 1'b0; branch_taken_ex = 1'b0;
    ALUOp_ex = 4'd0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    memread_ex = 1'b1; rd_ex = 5'd5; rs2_id = 5'd5; use_rs2_id = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("reset", NONE, 16'd0);
      tick();
    end

    rst_n = 1'b1;
    idle_inputs();
    check("idle", NONE, 16'd0);
    tick();

    memread_ex = 1'b1; rd_ex = 5'd5; rs2_id = 5'd5; use_rs2_id = 1'b1;
    check("lu_rs2", LU, 16'd0);
    tick();
    memread_ex = 1'b0;
    check("lu_once", NONE, 16'd1);
    tick();

    memread_ex = 1'b1; rd_ex = 5'd0; rs2_id = 5'd0;
    check("lu_x0", NONE, 16'd1);
    tick();

    idle_inputs();
    memread_ex = 1'b1; rd_ex = 5'd7; rs1_id = 5'd7; use_rs1_id = 1'b1;
    check("lu_rs1", LU, 16'd1);
    tick();
    use_rs1_id = 1'b0;
    check("lu_nouse", NONE, 16'd2);
    tick();

    idle_inputs();
    branch_taken_ex = 1'b1; ALUOp_ex = 4'b1010;
    check("br_prio", BR, 16'd2);
    tick();
    idle_inputs();
    check("br_run", NONE, 16'd2);
    tick();

    ALUOp_ex = 4'b1010;
    check("mul_t0", MCS, 16'd2);
    tick();
    ALUOp_ex = 4'd0; branch_taken_ex = 1'b1;
    check("mul_t1_br", BUSY, 16'd3);
    tick();
    branch_taken_ex = 1'b0;
    check("mul_t2", BUSY, 16'd4);
    tick();
    check("mul_t3_done", DONE, 16'd5);
    tick();
    ALUOp_ex = 4'b1011;
    check("b2b_start", MCS, 16'd6);
    tick();
    ALUOp_ex = 4'd0;
    check("b2b_t1", BUSY, 16'd7);
    tick();
    check("b2b_t2", BUSY, 16'd8);
    tick();
    check("b2b_done", DONE, 16'd9);
    tick();
    check("b2b_after", NONE, 16'd10);
    tick();

    ALUOp_ex = 4'b1011;
    check("div_t0", MCS, 16'd10);
    tick();
    ALUOp_ex = 4'd0;
    check("div_t1", BUSY, 16'd11);
    tick();
    rst_n = 1'b0;
    check("div_rst", NONE, 16'd0);
    tick();
    rst_n = 1'b1;
    check("div_run", NONE, 16'd0);
    tick();
    check("div_nodone", NONE, 16'd0);
    tick();

    memread_ex = 1'b1; rd_ex = 5'd3; rs1_id = 5'd3; use_rs1_id = 1'b1;
    repeat (65540) tick();
    check("sat_hold", LU, 16'hFFFF);
    tick();
    check("sat_stay", LU, 16'hFFFF);
    tick();
    idle_inputs();
    check("sat_idle", NONE, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
